f_adder: RTL and testbench
==========================

F_ADDER -- requirements
Module: f_adder

Interface
REQ-001 No parameters; format fixed at IEEE-754 binary16 (1 sign, 5 exponent, 10 fraction, bias 15).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 in_valid  input  1  high: a/b sampled this edge.
REQ-005 a  input  16  operand A, binary16 (bit15 sign, [14:10] exponent, [9:0] fraction).
REQ-006 b  input  16  operand B, binary16.
REQ-007 out_valid  output  1  high: op holds the result of the pair sampled 2 edges earlier.
REQ-008 op  output  16  sum a+b, binary16.

Function
REQ-009 Latency SHALL be exactly 2 clocks: pair sampled at edge N gives op/out_valid valid after edge N+2.
REQ-010 The block SHALL be fully pipelined, accepting one pair per clock, with no backpressure.
REQ-011 When in_valid is low, out_valid SHALL be low 2 clocks later; op SHALL hold its last value.
REQ-012 Alignment: the smaller-magnitude operand SHALL use the hidden 1 and be right-shifted by the exponent difference.
REQ-013 Shifted-out bits SHALL be kept as guard, round and sticky; for differences >13 the operand reduces to sticky only.
REQ-014 Like signs add significands; unlike signs subtract smaller from larger magnitude, result takes the larger operand's sign.
REQ-015 Normalization: carry-out SHALL shift right 1 and increment exponent; leading zeros SHALL shift left with exponent decremented.
REQ-016 Rounding SHALL be round-to-nearest, ties-to-even; rounding carry SHALL renormalize and increment exponent.
REQ-017 Subnormal inputs (exponent 0) SHALL be treated as zero of the same sign.
REQ-018 A result below the minimum normal (exponent would be <=0) SHALL flush to +0.
REQ-019 Exact cancellation SHALL give +0 (0x0000); (-0)+(-0) SHALL give 0x8000.
REQ-020 A result with exponent >=31 after rounding SHALL be infinity of the result sign (0x7C00/0xFC00).
REQ-021 Inf + finite SHALL give that inf; inf + same-sign inf SHALL give that inf.
REQ-022 inf + opposite inf SHALL give canonical NaN 0x7E00.
REQ-023 Any NaN operand SHALL give canonical NaN 0x7E00.
REQ-024 Addition SHALL be commutative bit-exactly: op(a,b) == op(b,a).

Reset
REQ-025 While rst_n is low, out_valid and op SHALL be 0 immediately, independent of clk.
REQ-026 Reset SHALL clear all pipeline valid bits; in-flight operations SHALL be discarded, producing no out_valid after release.
REQ-027 The first pair sampled on the first rising edge with rst_n high SHALL appear 2 clocks later.

Verification
REQ-028 a=0x3FB1, b=0x5733 -> op=0x5752 (117.11; RNE rounds up fraction 849->850), out_valid 2 clocks later.
REQ-029 Basic and rounding cases -> required op:
- 0x3C00+0x3C00 -> 0x4000.
- 0x3C00+0xBC00 -> 0x0000.
- 0x3C00+0x1000 (tie) -> 0x3C00.
- 0x3C01+0x1000 (tie) -> 0x3C02.
REQ-030 Overflow and NaN cases -> required op:
- 0x7BFF+0x7BFF -> 0x7C00.
- 0x7C00+0xFC00 -> 0x7E00.
- 0x7E00+0x3C00 -> 0x7E00.
- 0x7C00+0xC000 -> 0x7C00.
REQ-031 Subnormal case: 0x0001+0x0000 -> 0x0000.
REQ-032 Back-to-back pairs on consecutive clocks, then in_valid low -> results in order, one per clock, then out_valid low.
REQ-033 Reset mid-operation: pair issued, rst_n pulsed low the next cycle -> op=0 and out_valid=0 at once; no out_valid for that pair after release.

Source files
------------

// File: rtl/f_adder.sv
// f_adder: IEEE-754 binary16 adder with a three-register pipeline.
// Register ranks: stage 1 holds the decoded and aligned operands, stage 2 holds
// the significand sum, and op holds the normalized and rounded result. A pair
// sampled at edge N therefore appears on op/out_valid after edge N+2.
module f_adder (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        out_valid,
    output logic [15:0] op
);

    localparam logic [15:0] QNAN = 16'h7E00;

    // Returns the position of the leading one, counted down from bit 13.
    function automatic logic [3:0] lzc14(input logic [13:0] x);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 14; i++) begin
            if (x[i]) n = 4'(13 - i);
        end
        return n;
    endfunction

    // Round to nearest, ties to even, then pack. Handles the rounding carry,
    // flush of sub-minimum results to +0 and overflow to infinity.
    function automatic logic [15:0] round_pack(input logic sgn, input logic [10:0] man,
                                               input logic g, input logic rs,
                                               input logic signed [6:0] e);
        logic [11:0]       mr;
        logic signed [6:0] er;
        logic              up;
        up = g & (rs | man[0]);
        mr = {1'b0, man} + {11'd0, up};
        er = e;
        if (mr[11]) begin
            mr = 12'h400;
            er = e + 7'sd1;
        end
        if (er <= 7'sd0)       return 16'h0000;
        else if (er >= 7'sd31) return {sgn, 5'h1F, 10'd0};
        else                   return {sgn, er[4:0], mr[9:0]};
    endfunction

    // Decode and alignment signals
    logic [4:0]  exp_a, exp_b, exp_s, diff;
    logic [10:0] man_a, man_b, man_s;
    logic [14:0] key_a, key_b;
    logic        nan_a, nan_b, inf_a, inf_b, a_big;
    logic [25:0] sh;

    logic        s1_sign_d, s1_sub_d, s1_stk_d, s1_spec_d, s1_zsgn_d;
    logic [4:0]  s1_exp_d;
    logic [10:0] s1_mbig_d;
    logic [12:0] s1_msml_d;
    logic [15:0] s1_sval_d;

    logic        s1_sign_q, s1_sub_q, s1_stk_q, s1_spec_q, s1_zsgn_q;
    logic [4:0]  s1_exp_q;
    logic [10:0] s1_mbig_q;
    logic [12:0] s1_msml_q;
    logic [15:0] s1_sval_q;

    logic [14:0] s2_sum_d;
    logic [14:0] s2_sum_q;
    logic [4:0]  s2_exp_q;
    logic        s2_sign_q, s2_zsgn_q, s2_spec_q;
    logic [15:0] s2_sval_q;

    logic              v1_q, v2_q, out_valid_q;
    logic [15:0]       op_d, op_q;
    logic [13:0]       nrm;
    logic [3:0]        lz;
    logic signed [6:0] e_base;

    // Stage 1: classify operands, order by magnitude, align the smaller one
    always_comb begin
        exp_a = a[14:10];
        exp_b = b[14:10];
        man_a = (exp_a == 5'd0) ? 11'd0 : {1'b1, a[9:0]};
        man_b = (exp_b == 5'd0) ? 11'd0 : {1'b1, b[9:0]};
        key_a = (exp_a == 5'd0) ? 15'd0 : a[14:0];
        key_b = (exp_b == 5'd0) ? 15'd0 : b[14:0];
        nan_a = (exp_a == 5'h1F) && (a[9:0] != 10'd0);
        nan_b = (exp_b == 5'h1F) && (b[9:0] != 10'd0);
        inf_a = (exp_a == 5'h1F) && (a[9:0] == 10'd0);
        inf_b = (exp_b == 5'h1F) && (b[9:0] == 10'd0);
        a_big = key_a >= key_b;

        s1_sign_d = a_big ? a[15] : b[15];
        s1_sub_d  = a[15] ^ b[15];
        s1_zsgn_d = a[15] & b[15];
        s1_exp_d  = a_big ? exp_a : exp_b;
        s1_mbig_d = a_big ? man_a : man_b;
        exp_s     = a_big ? exp_b : exp_a;
        man_s     = a_big ? man_b : man_a;
        diff      = s1_exp_d - exp_s;
        sh        = {man_s, 15'd0} >> diff;
        if (diff > 5'd13) begin
            s1_msml_d = 13'd0;
            s1_stk_d  = |man_s;
        end else begin
            s1_msml_d = sh[25:13];
            s1_stk_d  = |sh[12:0];
        end

        s1_spec_d = 1'b1;
        s1_sval_d = QNAN;
        if (nan_a || nan_b || (inf_a && inf_b && (a[15] != b[15]))) s1_sval_d = QNAN;
        else if (inf_a)                                               s1_sval_d = {a[15], 15'h7C00};
        else if (inf_b)                                               s1_sval_d = {b[15], 15'h7C00};
        else                                                          s1_spec_d = 1'b0;
    end

    // Stage 2: add or subtract the aligned significands with guard/round/sticky
    always_comb begin
        if (s1_sub_q) s2_sum_d = {1'b0, s1_mbig_q, 3'b000} - {1'b0, s1_msml_q, s1_stk_q};
        else          s2_sum_d = {1'b0, s1_mbig_q, 3'b000} + {1'b0, s1_msml_q, s1_stk_q};
    end

    // Output stage: normalize, round and select special results
    always_comb begin
        e_base = signed'({2'b00, s2_exp_q});
        lz     = lzc14(s2_sum_q[13:0]);
        nrm    = s2_sum_q[13:0] << lz;
        if (s2_spec_q)
            op_d = s2_sval_q;
        else if (s2_sum_q == 15'd0)
            op_d = {s2_zsgn_q, 15'd0};
        else if (s2_sum_q[14])
            op_d = round_pack(s2_sign_q, s2_sum_q[14:4], s2_sum_q[3], |s2_sum_q[2:0],
                              e_base + 7'sd1);
        else
            op_d = round_pack(s2_sign_q, nrm[13:3], nrm[2], |nrm[1:0],
                              e_base - signed'({3'b000, lz}));
    end

    // Pipeline valid bits and the result register; reset discards in-flight pairs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1_q        <= 1'b0;
            v2_q        <= 1'b0;
            out_valid_q <= 1'b0;
            op_q        <= 16'h0000;
        end else begin
            v1_q        <= in_valid;
            v2_q        <= v1_q;
            out_valid_q <= v2_q;
            if (v2_q) op_q <= op_d;
        end
    end

    // Datapath registers for stages 1 and 2
    always_ff @(posedge clk) begin
        s1_sign_q <= s1_sign_d;
        s1_sub_q  <= s1_sub_d;
        s1_stk_q  <= s1_stk_d;
        s1_spec_q <= s1_spec_d;
        s1_zsgn_q <= s1_zsgn_d;
        s1_exp_q  <= s1_exp_d;
        s1_mbig_q <= s1_mbig_d;
        s1_msml_q <= s1_msml_d;
        s1_sval_q <= s1_sval_d;
        s2_sum_q  <= s2_sum_d;
        s2_exp_q  <= s1_exp_q;
        s2_sign_q <= s1_sign_q;
        s2_zsgn_q <= s1_zsgn_q;
        s2_spec_q <= s1_spec_q;
        s2_sval_q <= s1_sval_q;
    end

    assign out_valid = out_valid_q;
    assign op        = op_q;

endmodule

// File: tb/tb_f_adder.sv
// tb_f_adder: directed and randomized stimulus for f_adder, compared against
// an exact-integer binary16 reference model with two-clock latency tracking.
module tb_f_adder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [15:0] a, b;
    logic        out_valid;
    logic [15:0] op;

    int checks = 0;
    int errors = 0;

    logic        qv[$];
    logic [15:0] qe[$];
    logic [15:0] last_op;
    logic [15:0] prev_a, prev_b;

    localparam int ND = 16;
    localparam logic [15:0] DA [ND] = '{16'h3FB1, 16'h3C00, 16'h3C00, 16'h3C00, 16'h3C01, 16'h7BFF,
                                        16'h7C00, 16'h7E00, 16'h7C00, 16'h0001, 16'h8000, 16'h8001,
                                        16'h0800, 16'h0401, 16'h5733, 16'h3C00};
    localparam logic [15:0] DB [ND] = '{16'h5733, 16'h3C00, 16'hBC00, 16'h1000, 16'h1000, 16'h7BFF,
                                        16'hFC00, 16'h3C00, 16'hC000, 16'h0000, 16'h8000, 16'h8000,
                                        16'h8400, 16'h8400, 16'h3FB1, 16'h8000};
    localparam logic [15:0] DE [ND] = '{16'h5752, 16'h4000, 16'h0000, 16'h3C00, 16'h3C02, 16'h7C00,
                                        16'h7E00, 16'h7E00, 16'h7C00, 16'h0000, 16'h8000, 16'h8000,
                                        16'h0400, 16'h0000, 16'h5752, 16'h3C00};

    f_adder dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .op        (op)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Value of a finite binary16 number in units of 2^-24; subnormals read as zero.
    function automatic longint val16(input logic [15:0] x);
        longint m;
        if (x[14:10] == 5'd0) return 0;
        m = longint'({1'b1, x[9:0]}) << (x[14:10] - 5'd1);
        return x[15] ? -m : m;
    endfunction

    // Exact sum, then round-to-nearest-even into binary16.
    function automatic logic [15:0] ref_add(input logic [15:0] x, input logic [15:0] y);
        logic   xn, yn, xi, yi, sg;
        longint s, mag, q, rem, half;
        int     p, e, sh;
        xn = (x[14:10] == 5'h1F) && (x[9:0] != 0);
        yn = (y[14:10] == 5'h1F) && (y[9:0] != 0);
        xi = (x[14:10] == 5'h1F) && (x[9:0] == 0);
        yi = (y[14:10] == 5'h1F) && (y[9:0] == 0);
        if (xn || yn) return 16'h7E00;
        if (xi && yi) return (x[15] == y[15]) ? x : 16'h7E00;
        if (xi) return x;
        if (yi) return y;
        s = val16(x) + val16(y);
        if (s == 0) return (x[15] & y[15]) ? 16'h8000 : 16'h0000;
        sg  = (s < 0);
        mag = sg ? -s : s;
        p = 0;
        for (int i = 0; i < 48; i++) if (mag[i]) p = i;
        if (p < 10) return 16'h0000;
        e   = p - 9;
        sh  = p - 10;
        q   = mag >> sh;
        rem = mag - (q << sh);
        if (sh > 0) begin
            half = longint'(1) << (sh - 1);
            if (rem > half || (rem == half && q[0])) q++;
        end
        if (q == 2048) begin
            q = 1024;
            e++;
        end
        if (e >= 31) return {sg, 15'h7C00};
        return {sg, 5'(e), q[9:0]};
    endfunction

    // One clock: drive at negedge, record the sampled pair, check the pair from two edges back.
    task automatic step(input logic v, input logic [15:0] x, input logic [15:0] y,
                        input logic [15:0] e, input string tag);
        logic        ev;
        logic [15:0] ee;
        in_valid = v;
        a = x;
        b = y;
        @(posedge clk);
        qv.push_back(v);
        qe.push_back(e);
        #1;
        if (qv.size() > 2) begin
            ev = qv.pop_front();
            ee = qe.pop_front();
        end else begin
            ev = 1'b0;
            ee = 16'h0000;
        end
        chk({tag, "_vld"}, {15'd0, out_valid}, {15'd0, ev});
        if (ev) begin
            chk(tag, op, ee);
            last_op = ee;
        end else begin
            chk({tag, "_hold"}, op, last_op);
        end
        @(negedge clk);
    endtask

    initial begin
        logic [15:0] x, y;
        int          m, ey;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        a        = 16'h0000;
        b        = 16'h0000;
        last_op  = 16'h0000;
        prev_a   = 16'h3C00;
        prev_b   = 16'h4000;
        #3;
        chk("rst_vld", {15'd0, out_valid}, 16'h0000);
        chk("rst_op", op, 16'h0000);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < ND; i++) step(1'b1, DA[i], DB[i], DE[i], "dir");
        repeat (3) step(1'b0, 16'h1234, 16'h4321, 16'h0000, "idle");

        step(1'b1, 16'h4000, 16'h4000, 16'h4400, "pre");
        in_valid = 1'b0;
        #1 rst_n = 1'b0;
        #1;
        chk("midrst_vld", {15'd0, out_valid}, 16'h0000);
        chk("midrst_op", op, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        qv.delete();
        qe.delete();
        last_op = 16'h0000;
        repeat (4) step(1'b0, 16'h0000, 16'h0000, 16'h0000, "post");
        step(1'b1, 16'h3C00, 16'h3C00, 16'h4000, "first");

        repeat (600) begin
            m = $urandom_range(0, 4);
            x = 16'($urandom);
            y = 16'($urandom);
            case (m)
                1: begin
                    ey = int'(x[14:10]) + int'($urandom_range(0, 6)) - 3;
                    if (ey < 1)  ey = 1;
                    if (ey > 30) ey = 30;
                    y[14:10] = 5'(ey);
                end
                2: begin
                    y[14:10] = ($urandom_range(0, 1) != 0) ? 5'h1F : 5'h00;
                    if ($urandom_range(0, 1) != 0) y[9:0] = 10'd0;
                end
                3: begin
                    x = prev_b;
                    y = prev_a;
                end
                4: begin
                    y = x ^ 16'h8000;
                    y[2:0] = 3'($urandom);
                end
                default: ;
            endcase
            prev_a = x;
            prev_b = y;
            step($urandom_range(0, 4) != 0, x, y, ref_add(x, y), "rnd");
        end
        repeat (3) step(1'b0, 16'h0000, 16'h0000, 16'h0000, "tail");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
